// File: rtl/cdb_writeback_arbiter.sv
// Writeback stage: per-unit result FIFOs (alu0, alu1, md) drained round-robin onto the CDB.
// Optional macro CDB_PERF_EN adds conflict_cnt, a saturating count of cycles with 2+ sources queued.
module cdb_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu0_valid,
  input  logic [TAG_W-1:0]  alu0_tag,
  input  logic [DATA_W-1:0] alu0_value,
  output logic              alu0_ready,
  input  logic              alu1_valid,
  input  logic [TAG_W-1:0]  alu1_tag,
  input  logic [DATA_W-1:0] alu1_value,
  output logic              alu1_ready,
  input  logic              md_valid,
  input  logic [TAG_W-1:0]  md_tag,
  input  logic [DATA_W-1:0] md_value,
  output logic              md_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  localparam int NSRC  = 3;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NSRC-1:0]   in_valid;
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   nonempty;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [TAG_W-1:0]  in_tag   [NSRC];
  logic [DATA_W-1:0] in_value [NSRC];
  logic [CNT_W-1:0]  count    [NSRC];
  logic [PTR_W-1:0]  head     [NSRC];
  logic [PTR_W-1:0]  tail     [NSRC];
  logic [TAG_W-1:0]  mem_tag   [NSRC][DEPTH];
  logic [DATA_W-1:0] mem_value [NSRC][DEPTH];
  logic [1:0]        last_src;
  logic [1:0]        grant_src;
  logic [1:0]        cand;
  logic              grant_vld;

  function automatic logic [1:0] wrap_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign in_valid    = {md_valid, alu1_valid, alu0_valid};
  assign in_tag[0]   = alu0_tag;
  assign in_tag[1]   = alu1_tag;
  assign in_tag[2]   = md_tag;
  assign in_value[0] = alu0_value;
  assign in_value[1] = alu1_value;
  assign in_value[2] = md_value;
  assign alu0_ready  = ready[0];
  assign alu1_ready  = ready[1];
  assign md_ready    = ready[2];

  // ready comes from the registered count only, so a full FIFO never accepts even when popped
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < NSRC; i++) begin
      ready[i]    = (count[i] != CNT_W'(DEPTH));
      nonempty[i] = (count[i] != '0);
      push[i]     = in_valid[i] && ready[i];
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_src = 2'd0;
    cand      = wrap_inc(last_src);
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_src = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NSRC; i++)
      pop[i] = grant_vld && (grant_src == 2'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        mem_tag[i][tail[i]]   <= in_tag[i];
        mem_value[i][tail[i]] <= in_value[i];
      end
    end
  end

  // last_src resets to md so the first search starts at alu0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= 2'd0;
      last_src  <= 2'd2;
    end else if (grant_vld) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= mem_tag[grant_src][head[grant_src]];
      cdb_value <= mem_value[grant_src][head[grant_src]];
      cdb_src   <= grant_src;
      last_src  <= grant_src;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_PERF_EN
  logic multi_queued;
  assign multi_queued = (nonempty[0] & nonempty[1]) | (nonempty[0] & nonempty[2]) |
                        (nonempty[1] & nonempty[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (multi_queued && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the writeback rules.
module tb_cdb_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              v [3];
  logic [TAG_W-1:0]  t [3];
  logic [DATA_W-1:0] d [3];
  logic              alu0_ready, alu1_ready, md_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [1:0]        cdb_src;
`ifdef CDB_PERF_EN
  logic [15:0]       conflict_cnt;
`endif

  ent_t              mq [3][$];
  int                m_last;
  logic              exp_valid;
  logic [TAG_W-1:0]  exp_tag;
  logic [DATA_W-1:0] exp_value;
  logic [1:0]        exp_src;
  logic [15:0]       exp_cnt;
  logic [2:0]        pushed;
  int                n_vec;
  int                n_err;

  cdb_writeback_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu0_valid(v[0]), .alu0_tag(t[0]), .alu0_value(d[0]), .alu0_ready(alu0_ready),
    .alu1_valid(v[1]), .alu1_tag(t[1]), .alu1_value(d[1]), .alu1_ready(alu1_ready),
    .md_valid(v[2]), .md_tag(t[2]), .md_value(d[2]), .md_ready(md_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
`ifdef CDB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_rdy();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (mq[i].size() != DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_last    = 2;
    exp_valid = 1'b0;
    exp_tag   = '0;
    exp_value = '0;
    exp_src   = 2'd0;
    exp_cnt   = '0;
    pushed    = '0;
  endtask

  task automatic new_item(input int i);
    t[i] = (i == 2) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    d[i] = $urandom;
  endtask

  // One rising edge: model pops the RR winner among queued results, then accepts pushes.
  task automatic step();
    int   ne;
    int   g;
    int   idx;
    ent_t e;
    ne = 0;
    for (int i = 0; i < 3; i++) if (mq[i].size() != 0) ne++;
    for (int i = 0; i < 3; i++) pushed[i] = v[i] && (mq[i].size() != DEPTH);
    g = -1;
    for (int k = 1; k <= 3; k++) begin
      idx = (m_last + k) % 3;
      if (g < 0 && mq[idx].size() != 0) g = idx;
    end
    if (g >= 0) begin
      e         = mq[g].pop_front();
      exp_valid = 1'b1;
      exp_tag   = e.tag;
      exp_value = e.value;
      exp_src   = 2'(g);
      m_last    = g;
    end else begin
      exp_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (pushed[i]) begin
        e.tag   = t[i];
        e.value = d[i];
        mq[i].push_back(e);
      end
    end
    if (ne >= 2 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    v[0] = 1'b1; t[0] = 3'd1; d[0] = 32'h11;
    step();
    t[0] = 3'd2; d[0] = 32'h22;
    step();
    v[0] = 1'b0;
    n_vec++;
    if (cdb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: cdb_valid got %b expected 1", cdb_valid);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== 2'd0) begin
      n_err++;
      $display("FAIL reset_cdb: got v=%b tag=%0d val=%h src=%0d expected all zero",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    n_vec++;
    if ({md_ready, alu1_ready, alu0_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 111", {md_ready, alu1_ready, alu0_ready});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    v[0] = 1'b1; t[0] = 3'd2; d[0] = 32'd7;
    step();
    v[0] = 1'b0;
    n_vec++;
    if (cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: cdb_valid got %b expected 0 one edge after push", cdb_valid);
    end
    step();
    n_vec++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_value !== 32'd7 || cdb_src !== 2'd0) begin
      n_err++;
      $display("FAIL single_bcast: got v=%b tag=%0d val=%0d src=%0d expected v=1 tag=2 val=7 src=0",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    step();
    n_vec++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 3'd2 || cdb_value !== 32'd7 || cdb_src !== 2'd0) begin
      n_err++;
      $display("FAIL single_hold: got v=%b tag=%0d val=%0d src=%0d expected v=0 tag=2 val=7 src=0",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
  endtask

  task automatic test_three_way();
    logic [TAG_W-1:0]  et [3];
    logic [DATA_W-1:0] ev [3];
    et[0] = 3'd1; ev[0] = 32'd5;
    et[1] = 3'd3; ev[1] = 32'd9;
    et[2] = 3'd4; ev[2] = 32'd42;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; t[i] = et[i]; d[i] = ev[i];
    end
    step();
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(k) || cdb_tag !== et[k] || cdb_value !== ev[k]) begin
        n_err++;
        $display("FAIL three_way[%0d]: got v=%b src=%0d tag=%0d val=%0d expected v=1 src=%0d tag=%0d val=%0d",
                 k, cdb_valid, cdb_src, cdb_tag, cdb_value, k, et[k], ev[k]);
      end
    end
    step();
    n_vec++;
    if (cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL three_way_idle: cdb_valid got %b expected 0", cdb_valid);
    end
`ifdef CDB_PERF_EN
    n_vec++;
    if (conflict_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL three_way_conflict: conflict_cnt got %0d expected 2", conflict_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    ent_t sent [4];
    ent_t got [$];
    ent_t e;
    int   idx;
    logic saw_full;
    for (int k = 0; k < 4; k++) begin
      sent[k].tag   = 3'(k);
      sent[k].value = 32'hA000 + k;
    end
    do_reset();
    idx = 0;
    saw_full = 1'b0;
    new_item(1); new_item(2);
    v[1] = 1'b1; v[2] = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (idx < 4) begin
        v[0] = 1'b1; t[0] = sent[idx].tag; d[0] = sent[idx].value;
      end else begin
        v[0] = 1'b0;
      end
      step();
      if (pushed[0]) idx++;
      if (pushed[1]) new_item(1);
      if (pushed[2]) new_item(2);
      if (idx >= 4) begin
        v[1] = 1'b0; v[2] = 1'b0;
      end
      n_vec++;
      if ({md_ready, alu1_ready, alu0_ready} !== exp_rdy() || cdb_valid !== exp_valid ||
          cdb_tag !== exp_tag || cdb_value !== exp_value || cdb_src !== exp_src) begin
        n_err++;
        $display("FAIL bp_cyc%0d: got rdy=%b v=%b tag=%0d val=%h src=%0d expected rdy=%b v=%b tag=%0d val=%h src=%0d",
                 cyc, {md_ready, alu1_ready, alu0_ready}, cdb_valid, cdb_tag, cdb_value, cdb_src,
                 exp_rdy(), exp_valid, exp_tag, exp_value, exp_src);
      end
      if (!alu0_ready) saw_full = 1'b1;
      if (cdb_valid && cdb_src == 2'd0) begin
        e.tag = cdb_tag; e.value = cdb_value;
        got.push_back(e);
      end
    end
    n_vec++;
    if (saw_full !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full: alu0_ready low seen=%b expected 1", saw_full);
    end
    n_vec++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL bp_count: alu0 broadcasts got %0d expected 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got[k] !== sent[k]) begin
          n_err++;
          $display("FAIL bp_order[%0d]: got tag=%0d val=%h expected tag=%0d val=%h",
                   k, got[k].tag, got[k].value, sent[k].tag, sent[k].value);
        end
      end
    end
  endtask

  task automatic test_rr_fairness();
    int exp_alt;
    int grants;
    int since [3];
    int max_wait;
    do_reset();
    exp_alt = 0;
    grants = 0;
    max_wait = 0;
    since[0] = 0; since[1] = 0; since[2] = 0;
    new_item(0); new_item(2);
    v[0] = 1'b1; v[2] = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (pushed[0]) new_item(0);
      if (pushed[2]) new_item(2);
      n_vec++;
      if (cdb_valid !== exp_valid || cdb_tag !== exp_tag || cdb_value !== exp_value ||
          cdb_src !== exp_src) begin
        n_err++;
        $display("FAIL rr_model_cyc%0d: got v=%b tag=%0d val=%h src=%0d expected v=%b tag=%0d val=%h src=%0d",
                 cyc, cdb_valid, cdb_tag, cdb_value, cdb_src, exp_valid, exp_tag, exp_value, exp_src);
      end
      if (cdb_valid) begin
        n_vec++;
        if (cdb_src !== 2'(exp_alt)) begin
          n_err++;
          $display("FAIL rr_alternate_cyc%0d: src got %0d expected %0d", cyc, cdb_src, exp_alt);
        end
        exp_alt = (exp_alt == 0) ? 2 : 0;
        grants++;
      end
      if (grants > 0) begin
        for (int i = 0; i < 3; i += 2) begin
          if (cdb_valid && cdb_src == 2'(i)) since[i] = 0;
          else since[i]++;
          if (since[i] > max_wait) max_wait = since[i];
        end
      end
    end
    v[0] = 1'b0; v[2] = 1'b0;
    n_vec++;
    if (grants < 25) begin
      n_err++;
      $display("FAIL rr_grants: got %0d grants expected at least 25", grants);
    end
    n_vec++;
    if (max_wait > 2) begin
      n_err++;
      $display("FAIL rr_wait: longest wait got %0d cycles expected at most 2", max_wait);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; new_item(i);
    end
    step();
    v[1] = 1'b0; v[2] = 1'b0;
    new_item(0);
    step();
    v[0] = 1'b0;
    n_vec++;
    if (cdb_valid !== 1'b1 || mq[0].size() + mq[1].size() + mq[2].size() != 3) begin
      n_err++;
      $display("FAIL midrst_pre: cdb_valid got %b expected 1 with 3 queued", cdb_valid);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (cdb_valid !== 1'b0 || {md_ready, alu1_ready, alu0_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b rdy=%b expected v=0 rdy=111",
               cdb_valid, {md_ready, alu1_ready, alu0_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (cdb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_drop[%0d]: cdb_valid got %b expected 0", k, cdb_valid);
      end
    end
    v[2] = 1'b1; t[2] = 3'd5; d[2] = 32'h1234;
    step();
    v[2] = 1'b0;
    n_vec++;
    if (cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_latency: cdb_valid got %b expected 0", cdb_valid);
    end
    step();
    n_vec++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_value !== 32'h1234 || cdb_src !== 2'd2) begin
      n_err++;
      $display("FAIL midrst_bcast: got v=%b tag=%0d val=%h src=%0d expected v=1 tag=5 val=1234 src=2",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; new_item(i);
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(0, 9) < 6) begin
          v[i] = 1'b1;
          new_item(i);
        end
      end
      step();
      for (int i = 0; i < 3; i++) if (pushed[i]) v[i] = 1'b0;
      n_vec++;
      if ({md_ready, alu1_ready, alu0_ready} !== exp_rdy() || cdb_valid !== exp_valid ||
          cdb_tag !== exp_tag || cdb_value !== exp_value || cdb_src !== exp_src) begin
        n_err++;
        $display("FAIL rand_cyc%0d: got rdy=%b v=%b tag=%0d val=%h src=%0d expected rdy=%b v=%b tag=%0d val=%h src=%0d",
                 cyc, {md_ready, alu1_ready, alu0_ready}, cdb_valid, cdb_tag, cdb_value, cdb_src,
                 exp_rdy(), exp_valid, exp_tag, exp_value, exp_src);
      end
`ifdef CDB_PERF_EN
      n_vec++;
      if (conflict_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL rand_conflict_cyc%0d: conflict_cnt got %0d expected %0d",
                 cyc, conflict_cnt, exp_cnt);
      end
`endif
    end
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; t[i] = '0; d[i] = '0;
    end
    model_reset();
    test_reset();
    test_single();
    test_three_way();
    test_backpressure();
    test_rr_fairness();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
